// File: rtl/overlay_sink.sv
// Overlay pixel stream sink: buffers input words in a small FIFO and issues byte-masked writes
// to a double-buffered frame memory. It also tracks frame-bit toggles and keeps word and drop statistics.
module overlay_sink #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_ADDR = 63304,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [53:0]      din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [17:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_be,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic             frame_done,
   input  logic             frame_done_ack,
   output logic [CNT_W-1:0] last_count,
   output logic [7:0]       drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

   logic [53:0]      r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;
   logic             r_rdy;
   logic             r_first;
   logic             r_cur;
   logic             r_done;
   logic [CNT_W-1:0] r_wcnt;
   logic [CNT_W-1:0] r_last;
   logic [7:0]       r_drop;

   logic        w_full;
   logic        w_empty;
   logic        w_acc;
   logic        w_drop;
   logic        w_push;
   logic        w_pop;
   logic        w_toggle;
   logic [3:0]  w_mask;
   logic        w_frame;
   logic [16:0] w_addr;
   logic [53:0] w_head;

   assign w_mask  = din[53:50];
   assign w_frame = din[49];
   assign w_addr  = din[48:32];

   assign w_full   = (r_cnt == L_FULL);
   assign w_empty  = (r_cnt == '0);
   // r_rdy keeps din_ready low while reset is held, without a path from the reset pin
   assign din_ready = r_rdy & ~w_full;
   assign w_acc    = din_valid & din_ready;
   assign w_drop   = (w_mask == 4'h0) || (32'(w_addr) > MAX_ADDR);
   assign w_push   = w_acc & ~w_drop;
   assign w_pop    = ~w_empty & mem_ready;
   assign w_toggle = w_acc & ~r_first & (w_frame != r_cur);

   assign w_head    = r_mem[r_rd];
   assign mem_valid = ~w_empty;
   assign mem_addr  = w_empty ? '0 : w_head[53:36];
   assign mem_be    = w_empty ? '0 : w_head[35:32];
   assign mem_wdata = w_empty ? '0 : w_head[31:0];

   assign frame_done = r_done;
   assign last_count = r_last;
   assign drop_count = r_drop;

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr] <= {w_frame, w_addr, w_mask, din[31:0]};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
         r_rdy <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_first <= 1'b1;
         r_cur   <= 1'b0;
         r_done  <= 1'b0;
         r_wcnt  <= '0;
         r_last  <= '0;
         r_drop  <= '0;
      end else begin
         if (w_acc) begin
            if (r_first) begin
               r_cur   <= w_frame;
               r_wcnt  <= CNT_W'(1);
               r_first <= 1'b0;
            end else if (w_frame != r_cur) begin
               r_last <= r_wcnt;
               r_wcnt <= CNT_W'(1);
               r_cur  <= w_frame;
            end else if (r_wcnt != '1) begin
               r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
         end
         // A toggle wins over an ack that arrives in the same cycle
         if (w_toggle)            r_done <= 1'b1;
         else if (frame_done_ack) r_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_overlay_sink.sv
// Scoreboard bench for overlay_sink: expected writes are queued on accept and popped on mem handshakes.
module tb_overlay_sink;

   localparam int unsigned MAXA = 63304;

   logic        clock = 1'b0;
   logic        reset;
   logic [53:0] din;
   logic        din_valid;
   logic        din_ready;
   logic [17:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_valid;
   logic        mem_ready;
   logic        frame_done;
   logic        frame_done_ack;
   logic [15:0] last_count;
   logic [7:0]  drop_count;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   logic [53:0] sb[$];

   always #5 clock = ~clock;

   overlay_sink #(.DEPTH(4), .MAX_ADDR(MAXA), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_valid(mem_valid),
      .mem_ready(mem_ready), .frame_done(frame_done), .frame_done_ack(frame_done_ack),
      .last_count(last_count), .drop_count(drop_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the word was accepted.
   task automatic send(input logic [3:0] m, input logic f, input logic [16:0] a,
                       input logic [31:0] p, input logic ack_with);
      int n = 0;
      din = {m, f, a, p};
      din_valid = 1'b1;
      frame_done_ack = ack_with;
      @(negedge clock);
      while (!din_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("accept", {63'd0, din_ready}, 64'd1);
      if (din_ready && m != 4'h0 && 32'(a) <= MAXA) sb.push_back({f, a, m, p});
      @(posedge clock);
      #1;
      din_valid = 1'b0;
      frame_done_ack = 1'b0;
   endtask

   task automatic ack_pulse();
      frame_done_ack = 1'b1;
      @(posedge clock);
      #1;
      frame_done_ack = 1'b0;
      chk("ack_clear", {63'd0, frame_done}, 64'd0);
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clock);
      while (mem_valid && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("drain", {63'd0, mem_valid}, 64'd0);
      @(posedge clock);
      #1;
   endtask

   // Output monitor: pops the scoreboard on each write, checks hold stability during stalls.
   initial begin
      logic        stall = 1'b0;
      logic [53:0] held = '0;
      logic [53:0] exp;
      forever begin
         @(negedge clock);
         if (!reset) begin
            stall = 1'b0;
         end else begin
            if (stall) chk("stall_hold", {10'd0, mem_addr, mem_be, mem_wdata}, {10'd0, held});
            if (mem_valid && mem_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_write", {63'd0, mem_valid}, 64'd0);
               end else begin
                  exp = sb.pop_front();
                  chk("write", {10'd0, mem_addr, mem_be, mem_wdata}, {10'd0, exp});
               end
            end
            stall = mem_valid && !mem_ready;
            held  = {mem_addr, mem_be, mem_wdata};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; din = '0; din_valid = 1'b0; mem_ready = 1'b0; frame_done_ack = 1'b0;
      #12;
      chk("rst_din_ready", {63'd0, din_ready}, 64'd0);
      chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
      chk("rst_mem_addr", {46'd0, mem_addr}, 64'd0);
      chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
      chk("rst_last_count", {48'd0, last_count}, 64'd0);
      chk("rst_drop_count", {56'd0, drop_count}, 64'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // single word, one-cycle latency
      mem_ready = 1'b1;
      send(4'hF, 1'b0, 17'd100, 32'h02020202, 1'b0);
      @(negedge clock);
      chk("sw_valid", {63'd0, mem_valid}, 64'd1);
      chk("sw_addr", {46'd0, mem_addr}, 64'h00064);
      @(negedge clock);
      chk("sw_empty", {63'd0, mem_valid}, 64'd0);
      @(posedge clock); #1;

      // backpressure: 4 fill the FIFO, the 5th stalls
      mem_ready = 1'b0;
      send(4'h1, 1'b0, 17'd1, 32'h11111111, 1'b0);
      send(4'h2, 1'b0, 17'd2, 32'h22222222, 1'b0);
      send(4'h4, 1'b0, 17'd3, 32'h33333333, 1'b0);
      send(4'h8, 1'b0, 17'd4, 32'h44444444, 1'b0);
      din = {4'h3, 1'b0, 17'd5, 32'h55555555};
      din_valid = 1'b1;
      repeat (3) begin
         @(negedge clock);
         chk("bp_full", {63'd0, din_ready}, 64'd0);
      end
      @(posedge clock); #1;
      din_valid = 1'b0;
      mem_ready = 1'b1;
      @(negedge clock);
      chk("bp_still_full", {63'd0, din_ready}, 64'd0);
      @(negedge clock);
      chk("bp_ready_back", {63'd0, din_ready}, 64'd1);
      @(posedge clock); #1;
      send(4'h3, 1'b0, 17'd5, 32'h55555555, 1'b0);
      send(4'hC, 1'b0, 17'd6, 32'h66666666, 1'b0);
      drain();

      // drop rule and address boundary
      send(4'h0, 1'b0, 17'd10, 32'hDEADBEEF, 1'b0);
      send(4'hF, 1'b0, 17'd63305, 32'hBADBAD00, 1'b0);
      @(negedge clock);
      chk("drop_no_write", {63'd0, mem_valid}, 64'd0);
      chk("drop_count2", {56'd0, drop_count}, 64'd2);
      @(posedge clock); #1;
      send(4'hF, 1'b0, 17'd63304, 32'hCAFEF00D, 1'b0);
      drain();

      // frame toggles: 10 words in frame 0 so far
      send(4'hF, 1'b1, 17'd0, $urandom, 1'b0);
      chk("tog1_done", {63'd0, frame_done}, 64'd1);
      chk("tog1_last", {48'd0, last_count}, 64'd10);
      ack_pulse();
      for (int i = 1; i < 64; i++) send(4'hF, 1'b1, 17'(i), $urandom, 1'b0);
      chk("no_done_midframe", {63'd0, frame_done}, 64'd0);
      send(4'hF, 1'b0, 17'd200, $urandom, 1'b0);
      chk("tog2_done", {63'd0, frame_done}, 64'd1);
      chk("tog2_last", {48'd0, last_count}, 64'd64);
      ack_pulse();

      // collision: toggle and ack in the same cycle
      for (int i = 0; i < 9; i++) send(4'h5, 1'b0, 17'(300 + i), $urandom, 1'b0);
      send(4'hA, 1'b1, 17'd400, $urandom, 1'b1);
      chk("coll_done", {63'd0, frame_done}, 64'd1);
      chk("coll_last", {48'd0, last_count}, 64'd10);
      ack_pulse();
      drain();

      // drop counter saturation
      for (int i = 0; i < 255; i++) send(4'h0, 1'b1, 17'd1, 32'd0, 1'b0);
      chk("drop_sat", {56'd0, drop_count}, 64'hFF);

      // asynchronous reset with words queued and frame_done set
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(4'hF, 1'b0, 17'(500 + i), $urandom, 1'b0);
      chk("pre_rst_done", {63'd0, frame_done}, 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_din_ready", {63'd0, din_ready}, 64'd0);
      chk("arst_mem", {10'd0, mem_addr, mem_be, mem_wdata}, 64'd0);
      chk("arst_mem_valid", {63'd0, mem_valid}, 64'd0);
      chk("arst_done", {63'd0, frame_done}, 64'd0);
      chk("arst_last", {48'd0, last_count}, 64'd0);
      chk("arst_drop", {56'd0, drop_count}, 64'd0);
      sb.delete();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      mem_ready = 1'b1;
      send(4'hF, 1'b1, 17'd7, 32'h77777777, 1'b0);
      chk("first_after_rst", {63'd0, frame_done}, 64'd0);
      drain();
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
